// File: rtl/siso_shift_ctrl_if.sv
// Word-in / bit-out bundle for siso_shift_ctrl. The producer and consumer side
// drives through the master modport; the controller binds to the slave modport.
//
// Handshake: a word transfers on a rising edge where din_valid && din_ready.
// din_valid without din_ready has no effect, and the master may drop or change
// din at any time. A serial bit is consumed on every rising edge where
// sout_valid is high. The consumer holds stall high to pause; a stalled bit
// stays on sout with sout_valid low until stall drops.
interface siso_shift_ctrl_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             stall;
  logic             sout;
  logic             sout_valid;
  logic             first;
  logic             last;
  logic             done;

  modport master (
    output din, din_valid, stall,
    input  din_ready, sout, sout_valid, first, last, done
  );

  modport slave (
    input  din, din_valid, stall,
    output din_ready, sout, sout_valid, first, last, done
  );
endinterface

// File: rtl/siso_shift_ctrl.sv
// Parallel-to-serial sequencer: loads a word, then shifts it out LSB first with frame markers.
// Define SIMO_SHIFT_CTRL_PARITY_EN to append an even-parity bit (^din at load) after the data bits.
module siso_shift_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  siso_shift_ctrl_if.slave  bus,
  output logic [1:0]        state_dbg
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
`ifdef SIMO_SHIFT_CTRL_PARITY_EN
    ,
    PAR   = 2'd2
`endif
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] shreg, shreg_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             done_q, done_nx;

  logic din_ready_c;
  logic sout_c;
  logic sout_valid_c;
  logic first_c;
  logic last_c;

`ifdef SIMO_SHIFT_CTRL_PARITY_EN
  logic par_q, par_nx;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      shreg  <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
`ifdef SIMO_SHIFT_CTRL_PARITY_EN
      par_q  <= 1'b0;
`endif
    end else begin
      state  <= state_nx;
      shreg  <= shreg_nx;
      cnt    <= cnt_nx;
      done_q <= done_nx;
`ifdef SIMO_SHIFT_CTRL_PARITY_EN
      par_q  <= par_nx;
`endif
    end
  end

  always_comb begin
    state_nx     = state;
    shreg_nx     = shreg;
    cnt_nx       = cnt;
    done_nx      = 1'b0;
    din_ready_c  = 1'b0;
    sout_c       = 1'b0;
    sout_valid_c = 1'b0;
    first_c      = 1'b0;
    last_c       = 1'b0;
`ifdef SIMO_SHIFT_CTRL_PARITY_EN
    par_nx       = par_q;
`endif

    unique case (state)
      IDLE: begin
        // stall is deliberately ignored here so a word can be taken while paused
        din_ready_c = 1'b1;
        if (bus.din_valid) begin
          shreg_nx = bus.din;
          cnt_nx   = '0;
          state_nx = SHIFT;
`ifdef SIMO_SHIFT_CTRL_PARITY_EN
          par_nx   = ^bus.din;
`endif
        end
      end

      SHIFT: begin
        sout_c       = shreg[0];
        sout_valid_c = ~bus.stall;
        first_c      = (cnt == '0) && ~bus.stall;
`ifndef SIMO_SHIFT_CTRL_PARITY_EN
        last_c       = (cnt == LAST_CNT) && ~bus.stall;
`endif
        if (!bus.stall) begin
          shreg_nx = {1'b0, shreg[WIDTH-1:1]};
          if (cnt == LAST_CNT) begin
            // terminal count: clear instead of incrementing so cnt never wraps
            cnt_nx   = '0;
`ifdef SIMO_SHIFT_CTRL_PARITY_EN
            state_nx = PAR;
`else
            state_nx = IDLE;
            done_nx  = 1'b1;
`endif
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
      end

`ifdef SIMO_SHIFT_CTRL_PARITY_EN
      PAR: begin
        sout_c       = par_q;
        sout_valid_c = ~bus.stall;
        last_c       = ~bus.stall;
        if (!bus.stall) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
`endif

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign bus.din_ready  = din_ready_c;
  assign bus.sout       = sout_c;
  assign bus.sout_valid = sout_valid_c;
  assign bus.first      = first_c;
  assign bus.last       = last_c;
  assign bus.done       = done_q;
  assign state_dbg      = state;

endmodule
